// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: datapath widths, FXU opcodes, reservation-station entry.
// Also provides the CDB wakeup helper used by every slot and by the insert path.
package ooo_pkg;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 4;
    localparam int IMM_W  = 8;

    typedef enum logic [OP_W-1:0] {
        FXU_ADD  = 4'd0,
        FXU_SUB  = 4'd1,
        FXU_AND  = 4'd2,
        FXU_OR   = 4'd3,
        FXU_XOR  = 4'd4,
        FXU_NOR  = 4'd5,
        FXU_SLL  = 4'd6,
        FXU_SRL  = 4'd7,
        FXU_SRA  = 4'd8,
        FXU_SLT  = 4'd9,
        FXU_SLTU = 4'd10,
        FXU_ADDI = 4'd11,
        FXU_ANDI = 4'd12,
        FXU_ORI  = 4'd13,
        FXU_LUI  = 4'd14,
        FXU_MOV  = 4'd15
    } fxu_op_e;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  rob_idx;
        logic              a_vld;
        logic [DATA_W-1:0] a_val;
        logic [TAG_W-1:0]  a_tag;
        logic              b_vld;
        logic [DATA_W-1:0] b_val;
        logic [TAG_W-1:0]  b_tag;
        fxu_op_e           op;
        logic [IMM_W-1:0]  imm;
    } rs_entry_t;

    // Capture a broadcast result into any pending operand whose owner tag matches.
    function automatic rs_entry_t rs_wakeup(rs_entry_t e, logic cdb_vld,
                                            logic [TAG_W-1:0] cdb_tag,
                                            logic [DATA_W-1:0] cdb_val);
        rs_entry_t r;
        r = e;
        if (e.valid && cdb_vld) begin
            if (!e.a_vld && (e.a_tag == cdb_tag)) begin
                r.a_vld = 1'b1;
                r.a_val = cdb_val;
            end
            if (!e.b_vld && (e.b_tag == cdb_tag)) begin
                r.b_vld = 1'b1;
                r.b_val = cdb_val;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fxu_reservation_station_if.sv
// Dispatch, CDB snoop and FXU issue bundle for one reservation station.
// master = dispatch/CDB/FXU side, slave = the reservation station.
interface fxu_reservation_station_if;
    import ooo_pkg::*;

    logic              in_valid;
    logic [TAG_W-1:0]  in_rob_idx;
    logic              in_a_valid;
    logic [DATA_W-1:0] in_a_value;
    logic [TAG_W-1:0]  in_a_owner;
    logic              in_b_valid;
    logic [DATA_W-1:0] in_b_value;
    logic [TAG_W-1:0]  in_b_owner;
    logic [OP_W-1:0]   in_opcode;
    logic [IMM_W-1:0]  in_i;
    logic              full;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              flush;

    logic              ex_valid;
    logic              ex_ready;
    logic [TAG_W-1:0]  ex_rob_idx;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [OP_W-1:0]   ex_opcode;
    logic [IMM_W-1:0]  ex_i;

    modport master (
        output in_valid, in_rob_idx, in_a_valid, in_a_value, in_a_owner,
               in_b_valid, in_b_value, in_b_owner, in_opcode, in_i,
               cdb_valid, cdb_tag, cdb_value, flush, ex_ready,
        input  full, ex_valid, ex_rob_idx, ex_a, ex_b, ex_opcode, ex_i
    );

    modport slave (
        input  in_valid, in_rob_idx, in_a_valid, in_a_value, in_a_owner,
               in_b_valid, in_b_value, in_b_owner, in_opcode, in_i,
               cdb_valid, cdb_tag, cdb_value, flush, ex_ready,
        output full, ex_valid, ex_rob_idx, ex_a, ex_b, ex_opcode, ex_i
    );

endinterface

// File: rtl/fxu_reservation_station_rs_slot.sv
// One reservation-station entry: registers the next-state entry chosen by the top after
// CDB capture, and reports readiness. Defines: RS_CDB_BYPASS_EN (same-cycle CDB forwarding).
module rs_slot
    import ooo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  rs_entry_t         i_nxt,
    input  logic              i_cdb_vld,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_val,
    output rs_entry_t         o_ent,
    output logic              o_rdy,
    output logic [DATA_W-1:0] o_a_val,
    output logic [DATA_W-1:0] o_b_val
);

    rs_entry_t r_ent;
    logic      w_a_ok;
    logic      w_b_ok;

    // Wakeup is applied to whatever lands here, so shifted and newly inserted entries snoop too.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ent <= '0;
        end else begin
            r_ent <= rs_wakeup(i_nxt, i_cdb_vld, i_cdb_tag, i_cdb_val);
        end
    end

`ifdef RS_CDB_BYPASS_EN
    logic w_a_hit;
    logic w_b_hit;

    always_comb begin
        w_a_hit = i_cdb_vld && !r_ent.a_vld && (r_ent.a_tag == i_cdb_tag);
        w_b_hit = i_cdb_vld && !r_ent.b_vld && (r_ent.b_tag == i_cdb_tag);
        w_a_ok  = r_ent.a_vld || w_a_hit;
        w_b_ok  = r_ent.b_vld || w_b_hit;
        o_a_val = r_ent.a_vld ? r_ent.a_val : i_cdb_val;
        o_b_val = r_ent.b_vld ? r_ent.b_val : i_cdb_val;
    end
`else
    always_comb begin
        w_a_ok  = r_ent.a_vld;
        w_b_ok  = r_ent.b_vld;
        o_a_val = r_ent.a_val;
        o_b_val = r_ent.b_val;
    end
`endif

    assign o_ent = r_ent;
    assign o_rdy = r_ent.valid && w_a_ok && w_b_ok;

endmodule

// File: rtl/fxu_reservation_station.sv
// FXU reservation station: compacting queue (slot 0 oldest), issues the oldest ready entry.
// Issue is combinational from registered slots; full is registered-state only. Defines: RS_CDB_BYPASS_EN.
module fxu_reservation_station
    import ooo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                      clk,
    input logic                      rst,
    fxu_reservation_station_if.slave rs_if
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0]  r_count;
    rs_entry_t         w_ent   [DEPTH];
    logic [DATA_W-1:0] w_a_val [DEPTH];
    logic [DATA_W-1:0] w_b_val [DEPTH];
    logic [DEPTH-1:0]  w_rdy;
    logic [SEL_W-1:0]  w_sel;
    logic              w_any;
    logic              w_full;
    logic              w_issue;
    logic              w_ins;
    logic [CNT_W-1:0]  w_ins_pos;
    rs_entry_t         w_new;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_issue = w_any && rs_if.ex_ready;
    assign w_ins   = rs_if.in_valid && !w_full && !rs_if.flush;
    // An issue implies r_count >= 1, so the decrement cannot underflow.
    assign w_ins_pos = w_issue ? (r_count - CNT_W'(1)) : r_count;

    always_comb begin
        w_new         = '0;
        w_new.valid   = 1'b1;
        w_new.rob_idx = rs_if.in_rob_idx;
        w_new.a_vld   = rs_if.in_a_valid;
        w_new.a_val   = rs_if.in_a_value;
        w_new.a_tag   = rs_if.in_a_owner;
        w_new.b_vld   = rs_if.in_b_valid;
        w_new.b_val   = rs_if.in_b_value;
        w_new.b_tag   = rs_if.in_b_owner;
        w_new.op      = fxu_op_e'(rs_if.in_opcode);
        w_new.imm     = rs_if.in_i;
    end

    // Lowest-index ready slot wins: scan from the top so the last hit is the oldest.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_rdy[k]) begin
                w_any = 1'b1;
                w_sel = SEL_W'(k);
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        rs_entry_t w_shift;
        rs_entry_t w_nxt;

        if (k < DEPTH - 1) begin : g_mid
            assign w_shift = w_ent[k+1];
        end else begin : g_last
            assign w_shift = '0;
        end

        // Insert position already accounts for the same-edge shift, so it overrides it.
        always_comb begin
            w_nxt = w_ent[k];
            if (w_issue && (SEL_W'(k) >= w_sel)) begin
                w_nxt = w_shift;
            end
            if (w_ins && (w_ins_pos == CNT_W'(k))) begin
                w_nxt = w_new;
            end
        end

        rs_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .i_clr     (rs_if.flush),
            .i_nxt     (w_nxt),
            .i_cdb_vld (rs_if.cdb_valid),
            .i_cdb_tag (rs_if.cdb_tag),
            .i_cdb_val (rs_if.cdb_value),
            .o_ent     (w_ent[k]),
            .o_rdy     (w_rdy[k]),
            .o_a_val   (w_a_val[k]),
            .o_b_val   (w_b_val[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || rs_if.flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_ins) - CNT_W'(w_issue);
        end
    end

    always_comb begin
        rs_if.full       = w_full;
        rs_if.ex_valid   = 1'b0;
        rs_if.ex_rob_idx = '0;
        rs_if.ex_a       = '0;
        rs_if.ex_b       = '0;
        rs_if.ex_opcode  = '0;
        rs_if.ex_i       = '0;
        if (w_any) begin
            rs_if.ex_valid   = 1'b1;
            rs_if.ex_rob_idx = w_ent[w_sel].rob_idx;
            rs_if.ex_a       = w_a_val[w_sel];
            rs_if.ex_b       = w_b_val[w_sel];
            rs_if.ex_opcode  = w_ent[w_sel].op;
            rs_if.ex_i       = w_ent[w_sel].imm;
        end
    end

    // Dispatch into a full station is dropped; flag it so the upstream bug is visible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(rs_if.in_valid && w_full))
                else $warning("dispatch while station full was dropped");
        end
    end

endmodule
